// File: rtl/cl_pkg.sv
// cl_pkg: shared type codes, field positions, error codes and states for the chart word assembler
package cl_pkg;
    localparam logic [2:0] CL_TYPE_NOTE = 3'b000;
    localparam logic [2:0] CL_TYPE_END  = 3'b111;
    localparam int CL_TYPE_MSB = 31;
    localparam int CL_TYPE_LSB = 29;
    localparam int CL_TIME_MSB = 15;
    localparam int CL_TIME_LSB = 0;
    typedef enum logic [1:0] {
        CL_ERR_BAD_TYPE = 2'd0,
        CL_ERR_OVERFLOW = 2'd1,
        CL_ERR_TIMEOUT  = 2'd2,
        CL_ERR_ORDER    = 2'd3
    } cl_err_e;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } cl_state_e;
endpackage

// File: rtl/cl_byte_timeout.sv
// cl_byte_timeout: clearable cycle counter that holds and flags once it reaches TIMEOUT_CYCLES
module cl_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q;
    assign expired = cnt_q == W'(TIMEOUT_CYCLES);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (clr) cnt_q <= '0;
        else if (en && !expired) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/cl_word_assembler.sv
// cl_word_assembler: packs bytes into validated 32-bit note words; CL_ORDER_CHECK_EN enables time-order check
module cl_word_assembler
    import cl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_WORDS      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        write_en,
    output logic [31:0] write_word,
    output logic [12:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    cl_state_e   state_q, state_d;
    cl_err_e     err_code_q, err_code_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;
    logic [12:0] count_q, count_d;
    logic        write_en_q, write_en_d;
    logic [31:0] write_word_q, write_word_d;
    logic        tmo_clr, tmo_en, tmo_expired;
    logic [31:0] full;
    logic [2:0]  typ;
`ifdef CL_ORDER_CHECK_EN
    logic [15:0] last_time_q, last_time_d;
`endif

    assign full = {shift_q, byte_data};
    assign typ  = full[CL_TYPE_MSB:CL_TYPE_LSB];

    cl_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign tmo_en  = state_q == ST_COLLECT && idx_q != 2'd0;
    assign tmo_clr = start || (state_q == ST_COLLECT && byte_valid);

    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        count_d      = count_q;
        write_en_d   = 1'b0;
        write_word_d = write_word_q;
`ifdef CL_ORDER_CHECK_EN
        last_time_d  = last_time_q;
`endif
        if (start) begin
            state_d    = ST_COLLECT;
            err_code_d = CL_ERR_BAD_TYPE;
            idx_d      = 2'd0;
            count_d    = '0;
`ifdef CL_ORDER_CHECK_EN
            last_time_d = '0;
`endif
        end else if (state_q == ST_COLLECT) begin
            if (tmo_expired) begin
                state_d    = ST_ERR;
                err_code_d = CL_ERR_TIMEOUT;
            end else if (byte_valid) begin
                idx_d   = idx_q + 2'd1;
                shift_d = full[23:0];
                if (idx_q == 2'd3) begin
                    if (typ != CL_TYPE_NOTE && typ != CL_TYPE_END) begin
                        state_d    = ST_ERR;
                        err_code_d = CL_ERR_BAD_TYPE;
                    end else if (count_q == 13'(MAX_WORDS)) begin
                        state_d    = ST_ERR;
                        err_code_d = CL_ERR_OVERFLOW;
`ifdef CL_ORDER_CHECK_EN
                    end else if (typ == CL_TYPE_NOTE && full[CL_TIME_MSB:CL_TIME_LSB] < last_time_q) begin
                        state_d    = ST_ERR;
                        err_code_d = CL_ERR_ORDER;
`endif
                    end else begin
                        write_en_d   = 1'b1;
                        write_word_d = full;
                        count_d      = count_q + 13'd1;
                        state_d      = typ == CL_TYPE_END ? ST_DONE : ST_COLLECT;
`ifdef CL_ORDER_CHECK_EN
                        last_time_d  = typ == CL_TYPE_NOTE ? full[CL_TIME_MSB:CL_TIME_LSB] : last_time_q;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            err_code_q   <= CL_ERR_BAD_TYPE;
            idx_q        <= '0;
            shift_q      <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            write_word_q <= '0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            write_word_q <= write_word_d;
        end
    end

`ifdef CL_ORDER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_time_q <= '0;
        else last_time_q <= last_time_d;
    end
`endif

    assign write_en   = write_en_q;
    assign write_word = write_word_q;
    assign word_count = count_q;
    assign busy       = state_q == ST_COLLECT;
    assign done       = state_q == ST_DONE;
    assign error      = state_q == ST_ERR;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_cl_word_assembler.sv
// tb_cl_word_assembler: directed and randomized checks of cl_word_assembler against a word-level model
module tb_cl_word_assembler;
    localparam int TMO  = 16;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        write_en;
    logic [31:0] write_word;
    logic [12:0] word_count;
    logic        busy, done, error;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;
    logic [31:0] got[$];
    bit [31:0] exp_q[$];
    int exp_cnt;
    bit exp_done, exp_err;
    int exp_code;
    bit [15:0] tbase;

    cl_word_assembler #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .write_en   (write_en),
        .write_word (write_word),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (write_en) got.push_back(write_word);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) begin
            send(w[8*k +: 8]);
            idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got.delete();
    endtask

    // Word-level reference: applies the validation rules to each complete word in order.
    task automatic model(input bit [31:0] ws[$]);
        bit [15:0] last = 16'h0;
        bit [2:0] t;
        exp_q.delete();
        exp_cnt = 0; exp_done = 0; exp_err = 0; exp_code = 0;
        foreach (ws[i]) begin
            if (exp_done || exp_err) break;
            t = ws[i][31:29];
            if (t != 3'b000 && t != 3'b111) begin
                exp_err = 1; exp_code = 0;
            end else if (exp_cnt == MAXW) begin
                exp_err = 1; exp_code = 1;
`ifdef CL_ORDER_CHECK_EN
            end else if (t == 3'b000 && ws[i][15:0] < last) begin
                exp_err = 1; exp_code = 3;
`endif
            end else begin
                exp_q.push_back(ws[i]);
                exp_cnt++;
                if (t == 3'b111) exp_done = 1;
                else last = ws[i][15:0];
            end
        end
    endtask

    function automatic bit [31:0] rand_word();
        int r;
        bit [2:0] t;
        bit [15:0] tm;
        r = $urandom_range(0, 9);
        t = r < 7 ? 3'b000 : (r < 8 ? 3'b111 : 3'($urandom_range(1, 6)));
        tm = ($urandom_range(0, 4) == 0) ? tbase - 16'($urandom_range(1, 20)) : tbase + 16'($urandom_range(0, 40));
        if (t == 3'b000) tbase = tm;
        return {t, 13'($urandom), tm};
    endfunction

    initial begin
        bit [31:0] ws[$];
        idle(2);
        check("rst_ctl", {31'(0), write_en}, 0);
        check("rst_word", write_word, 0);
        check("rst_cnt", 32'(word_count), 0);
        check("rst_flags", {28'(0), busy, done, error, 1'b0} | 32'(err_code), 0);
        rst_n = 1'b1;
        idle(1);
        send(8'h00); idle(2);
        check("idle_ignore", 32'(busy), 0);

        pulse_start();
        check("start_busy", 32'(busy), 1);
        send(8'h00); send(8'h81); send(8'h23); send(8'hE8);
        check("lat_we", 32'(write_en), 1);
        check("lat_word", write_word, 32'h008123E8);
        check("lat_cnt", 32'(word_count), 1);
        idle(1);
        check("we_single", 32'(write_en), 0);
        send(8'hE0); send(8'h00); send(8'h00); send(8'h00);
        check("norm_done", 32'(done), 1);
        check("norm_busy", 32'(busy), 0);
        check("norm_cnt", 32'(word_count), 2);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01); idle(2);
        check("norm_n", got.size(), 2);
        if (got.size() == 2) begin
            check("norm_w0", got[0], 32'h008123E8);
            check("norm_w1", got[1], 32'hE0000000);
        end
        check("norm_after_cnt", 32'(word_count), 2);

        pulse_start();
        check("restart_clr", {29'(0), done, error, busy}, 1);
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        check("bad_err", 32'(error), 1);
        check("bad_code", 32'(err_code), 0);
        send_word(32'h00000001, 0); idle(2);
        check("bad_n", got.size(), 0);
        check("bad_cnt", 32'(word_count), 0);

        pulse_start();
        idle(30);
        check("gap_noerr", 32'(error), 0);
        send(8'h00); send(8'h00);
        idle(10);
        check("tmo_early", 32'(error), 0);
        idle(10);
        check("tmo_err", 32'(error), 1);
        check("tmo_code", 32'(err_code), 2);
        check("tmo_busy", 32'(busy), 0);

        pulse_start();
        for (int i = 0; i < 5; i++) send_word(32'h00000010 + 32'(i), 1);
        idle(2);
        check("ovf_n", got.size(), 4);
        check("ovf_code", 32'(err_code), 1);
        check("ovf_err", 32'(error), 1);
        check("ovf_cnt", 32'(word_count), 4);

        pulse_start();
        send_word(32'h00000100, 0);
        send_word(32'h000000FF, 0);
        idle(2);
`ifdef CL_ORDER_CHECK_EN
        check("ord_n", got.size(), 1);
        check("ord_code", 32'(err_code), 3);
        check("ord_err", 32'(error), 1);
`else
        check("ord_n", got.size(), 2);
        check("ord_err", 32'(error), 0);
`endif

        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", {28'(0), busy, done, error, write_en}, 0);
        check("arst_cnt", 32'(word_count) | 32'(err_code), 0);
        check("arst_word", write_word, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h07); idle(3);
        check("arst_n", got.size() + 32'(busy), 0);

        start = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;
        got.delete();
        send(8'h00); send(8'h00); send(8'h00); send(8'h05);
        idle(2);
        check("coll_n", got.size(), 1);
        if (got.size() == 1) check("coll_w", got[0], 32'h00000005);

        for (int it = 0; it < 40; it++) begin
            ws.delete();
            tbase = 16'($urandom_range(100, 1000));
            for (int j = 0; j < $urandom_range(1, 6); j++) ws.push_back(rand_word());
            model(ws);
            pulse_start();
            foreach (ws[j]) send_word(ws[j], 2);
            idle(3);
            check("rnd_n", got.size(), exp_q.size());
            for (int j = 0; j < got.size() && j < exp_q.size(); j++) check("rnd_w", got[j], exp_q[j]);
            check("rnd_cnt", 32'(word_count), exp_cnt);
            check("rnd_done", 32'(done), 32'(exp_done));
            check("rnd_err", 32'(error), 32'(exp_err));
            check("rnd_busy", 32'(busy), 32'(!(exp_done || exp_err)));
            if (exp_err) check("rnd_code", 32'(err_code), exp_code);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cl_word_assembler.md
# cl_word_assembler

Upstream stage of the chart-loading path: takes the raw byte stream from the serial receiver, packs big-endian 4-byte groups into 32-bit note words, validates them, and presents each word as a single-cycle `write_en` / `write_word` strobe to the metadata controller. The block also tracks the word count and detects the end-of-data word. It reports load completion or a classified error to the game control logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum gap between bytes of one partial word (10 ms at 100 MHz).
- `MAX_WORDS`, default 4096: capacity of the downstream memory, including the end word.

Ports:
- `clk`  in  1  100 MHz system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; clears all state and arms a new load.
- `byte_valid`  in  1  `byte_data` is valid this cycle; may be high every cycle.
- `byte_data`  in  8  received byte.
- `write_en`  out  1  single-cycle strobe; `write_word` is valid this cycle.
- `write_word`  out  32  `[31:29]` type (000 note, 111 end), `[28:23]` pitch, `[22:20]` string, `[19:16]` fret, `[15:0]` time.
- `word_count`  out  13  number of words emitted since `start`.
- `busy`  out  1  high in COLLECT.
- `done`  out  1  sticky; end word has been emitted.
- `error`  out  1  sticky; load aborted.
- `err_code`  out  2  0 BAD_TYPE, 1 OVERFLOW, 2 TIMEOUT, 3 ORDER; valid while `error` is high.

## Operation
- States:
  - IDLE: reset state; bytes ignored.
  - COLLECT: assembling words.
  - DONE: terminal success state; bytes ignored.
  - ERR: terminal failure state; bytes ignored.
- `start` in any state:
  - Clears the byte index, `word_count`, `done`, `error`, `err_code`, the timeout counter and the last timestamp.
  - Next state is COLLECT.
  - If `start` and `byte_valid` are high in the same cycle, `start` wins and the byte is dropped.
- In COLLECT, each `byte_valid` shifts the byte into the shift register, MSB first, and increments the 2-bit byte index.
- On the 4th byte, the assembled word is checked in this order:
  - Type is neither 000 nor 111 → ERR with BAD_TYPE; no strobe.
  - `word_count == MAX_WORDS` → ERR with OVERFLOW; no strobe.
  - Otherwise the word is emitted and `word_count` increments.
- An end word (type 111) is emitted and counted, then the block moves to DONE. Bytes after the end word are ignored.
- Timeout:
  - The counter runs only while the byte index ≠ 0, and resets on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, the partial word is discarded and the block moves to ERR with TIMEOUT.
  - A gap between complete words is never a timeout.
- `word_count` saturates at `MAX_WORDS`; it cannot exceed that value because OVERFLOW is checked first.

## Timing
- All outputs are registered. Reset values: `write_en` 0, `write_word` 0, `word_count` 0, `busy` 0, `done` 0, `error` 0, `err_code` 0.
- Latency: `write_en` is high exactly 1 cycle after the cycle in which the 4th byte is accepted. `word_count` updates in the same cycle as the strobe.
- `done` or `error` rises in the same cycle as the final strobe, or in the cycle after the failing byte. `busy` falls in that same cycle.
- Sustained throughput is one byte per cycle, so the strobe rate is at most one strobe every 4 cycles, with no back-pressure.
- `rst_n` asserted mid-word drops the partial word and clears everything asynchronously. No strobe is emitted afterwards.

## Configuration
- `CL_ORDER_CHECK_EN` defined:
  - The time field of each note word must be ≥ the previous note's time.
  - A violation sends the block to ERR with ORDER and suppresses the strobe.
  - End words are exempt from this check.
- `CL_ORDER_CHECK_EN` undefined:
  - No timestamp register is built; times are unchecked.
  - `err_code` 3 is never produced.

## Structure
- Shared package `cl_pkg` holds:
  - Type codes `CL_TYPE_NOTE = 3'b000` and `CL_TYPE_END = 3'b111`.
  - Field bit positions.
  - The `err_code` encodings.
  - The state encoding.
- One sub-module, `cl_byte_timeout`: a resettable cycle counter with a terminal-count flag, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Normal load:
  - Stimulus: `start`, then bytes `00 81 23 E8` and `E0 00 00 00`.
  - Response: two strobes with words `0x008123E8` and `0xE0000000`; `word_count` = 2; `done` = 1; `busy` = 0.
- Bad type:
  - Stimulus: bytes `40 00 00 00`.
  - Response: no strobe; `error` = 1; `err_code` = 0; further bytes ignored.
- Timeout:
  - Stimulus: two bytes, then idle for `TIMEOUT_CYCLES` (test builds set the parameter to 16).
  - Response: `error` = 1; `err_code` = 2. An idle gap with the byte index at 0 produces no error.
- Overflow:
  - Stimulus: `MAX_WORDS` = 4; send 4 note words, then a 5th.
  - Response: 4 strobes; `err_code` = 1; `word_count` = 4.
- Order check (`CL_ORDER_CHECK_EN`):
  - Stimulus: a note with time 0x0100, then a note with time 0x00FF.
  - Response: one strobe; `err_code` = 3.
  - Without the macro, the same stimulus produces two strobes.
- Reset and start collisions:
  - Stimulus: assert `rst_n` low after 3 bytes, then release.
  - Response: all outputs 0 and no strobe.
  - Stimulus: `start` coincident with `byte_valid`.
  - Response: that byte is dropped; the next 4 bytes form a word.
